// File: rtl/ext_arbiter.sv
// ============================================================================
// Module      : ext_arbiter
// Description : Two-requester round-robin front end for a single 16->32-bit
//               immediate extender. Valid/ready on both sides, one-entry
//               registered result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1   clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   req0_valid     in   1   requester 0 has an operand
//   req0_imm       in  16   requester 0 immediate
//   req0_eop       in   2   requester 0 extension op
//   req0_ready     out  1   requester 0 operand accepted this cycle
//   req1_valid     in   1   requester 1 has an operand
//   req1_imm       in  16   requester 1 immediate
//   req1_eop       in   2   requester 1 extension op
//   req1_ready     out  1   requester 1 operand accepted this cycle
//   out_valid      out  1   out_ext/out_id hold a result
//   out_ready      in   1   consumer takes the result
//   out_ext        out 32   extended result
//   out_id         out  1   requester that owns out_ext
//   busy           out  1   high while a result is held
// ============================================================================
`default_nettype none

module ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [15:0] req0_imm,
  input  logic [1:0]  req0_eop,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_imm,
  input  logic [1:0]  req1_eop,
  output logic        req1_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_ext,
  output logic        out_id,
  output logic        busy
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state_q;
  logic        rr_ptr_q;
  logic        out_valid_q;
  logic [31:0] out_ext_q;
  logic        out_id_q;

  logic        grant0_w;
  logic        grant1_w;
  logic [15:0] sel_imm_w;
  logic [1:0]  sel_eop_w;
  logic [31:0] ext_d;

  // Extension ops: 00 sign, 01 zero, 10 upper-half, 11 sign then <<2.
  function automatic logic [31:0] extend(input logic [15:0] imm, input logic [1:0] eop);
    logic [31:0] sext;
    sext = {{16{imm[15]}}, imm};
    case (eop)
      2'b00:   extend = sext;
      2'b01:   extend = {16'h0000, imm};
      2'b10:   extend = {imm, 16'h0000};
      default: extend = {sext[29:0], 2'b00};
    endcase
  endfunction

  // A lone requester always wins; rr_ptr only breaks ties.
  always_comb begin
    grant0_w = 1'b0;
    grant1_w = 1'b0;
    if (state_q == ST_IDLE) begin
      grant0_w = req0_valid && (!req1_valid || (rr_ptr_q == 1'b0));
      grant1_w = req1_valid && (!req0_valid || (rr_ptr_q == 1'b1));
    end
  end

  always_comb begin
    sel_imm_w = grant1_w ? req1_imm : req0_imm;
    sel_eop_w = grant1_w ? req1_eop : req0_eop;
    ext_d     = extend(sel_imm_w, sel_eop_w);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_ext_q   <= 32'h0000_0000;
      out_id_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant0_w || grant1_w) begin
            out_ext_q   <= ext_d;
            out_id_q    <= grant1_w;
            out_valid_q <= 1'b1;
            rr_ptr_q    <= ~grant1_w;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // No new accept on the release edge: at most one result per two cycles.
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_ready = grant0_w;
  assign req1_ready = grant1_w;
  assign out_valid  = out_valid_q;
  assign out_ext    = out_ext_q;
  assign out_id     = out_id_q;
  assign busy       = (state_q == ST_HOLD);

endmodule

`default_nettype wire

// File: tb/tb_ext_arbiter.sv
// ============================================================================
// Module      : tb_ext_arbiter
// Description : Directed self-checking bench for ext_arbiter. Inputs change
//               just after the falling edge; checks run 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ext_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid;
  logic [15:0] req0_imm;
  logic [1:0]  req0_eop;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_imm;
  logic [1:0]  req1_eop;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ext;
  logic        out_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ext_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_imm   (req0_imm),
    .req0_eop   (req0_eop),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_imm   (req1_imm),
    .req1_eop   (req1_eop),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_ext    (out_ext),
    .out_id     (out_id),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One lone req0 transaction starting from IDLE at a falling edge.
  task automatic do_one(input string tag, input logic [15:0] imm, input logic [1:0] eop,
                        input logic [31:0] exp);
    req0_valid = 1'b1;
    req0_imm   = imm;
    req0_eop   = eop;
    out_ready  = 1'b1;
    #1;
    chk({tag, "_ready"}, req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_ext"}, out_ext, exp);
    chk({tag, "_id"}, out_id, 0);
    chk({tag, "_busy"}, busy, 1);
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    req0_valid = 1'b0;
    req0_imm   = 16'h0;
    req0_eop   = 2'b00;
    req1_valid = 1'b0;
    req1_imm   = 16'h0;
    req1_eop   = 2'b00;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ext", out_ext, 32'h0);
    chk("rst_id", out_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_r0rdy", req0_ready, 0);
    chk("rst_r1rdy", req1_ready, 0);

    // Asynchronous reset while holding a result.
    @(negedge clk);
    req0_valid = 1'b1;
    req0_imm   = 16'hF3D4;
    req0_eop   = 2'b00;
    out_ready  = 1'b0;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    chk("hold_busy", busy, 1);
    chk("hold_ext", out_ext, 32'hFFFF_F3D4);
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_ext", out_ext, 32'h0);
    chk("arst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;

    // Each extension op on F3D4.
    do_one("eop0", 16'hF3D4, 2'b00, 32'hFFFF_F3D4);
    do_one("eop1", 16'hF3D4, 2'b01, 32'h0000_F3D4);
    do_one("eop2", 16'hF3D4, 2'b10, 32'hF3D4_0000);
    do_one("eop3", 16'hF3D4, 2'b11, 32'hFFFF_CF50);

    // Both requesters valid after reset: r0, r1, r0.
    reset_pulse();
    req0_valid = 1'b1; req0_imm = 16'h0001; req0_eop = 2'b00;
    req1_valid = 1'b1; req1_imm = 16'h8000; req1_eop = 2'b01;
    out_ready  = 1'b1;
    #1;
    chk("rr1_r0rdy", req0_ready, 1);
    chk("rr1_r1rdy", req1_ready, 0);
    @(negedge clk); #1;
    chk("rr1_ext", out_ext, 32'h0000_0001);
    chk("rr1_id", out_id, 0);
    chk("rr1_hold_r0", req0_ready, 0);
    chk("rr1_hold_r1", req1_ready, 0);
    @(negedge clk); #1;
    chk("rr2_r0rdy", req0_ready, 0);
    chk("rr2_r1rdy", req1_ready, 1);
    @(negedge clk); #1;
    chk("rr2_ext", out_ext, 32'h0000_8000);
    chk("rr2_id", out_id, 1);
    @(negedge clk); #1;
    chk("rr3_r0rdy", req0_ready, 1);
    chk("rr3_r1rdy", req1_ready, 0);
    @(negedge clk);

    // Consumer stalls for five cycles.
    out_ready = 1'b0;
    #1;
    chk("rr3_ext", out_ext, 32'h0000_0001);
    chk("rr3_id", out_id, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_ext", out_ext, 32'h0000_0001);
      chk("stall_id", out_id, 0);
      chk("stall_busy", busy, 1);
      chk("stall_r0rdy", req0_ready, 0);
      chk("stall_r1rdy", req1_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("rel_busy", busy, 0);
    chk("rel_valid", out_valid, 0);
    chk("rel_r1rdy", req1_ready, 1);
    chk("rel_r0rdy", req0_ready, 0);
    @(negedge clk); #1;
    chk("rel_ext", out_ext, 32'h0000_8000);
    chk("rel_id", out_id, 1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Lone req1 with rr_ptr pointing at req0.
    reset_pulse();
    req1_valid = 1'b1; req1_imm = 16'h8000; req1_eop = 2'b00;
    out_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("solo_r1rdy", req1_ready, 1);
      @(negedge clk); #1;
      chk("solo_id", out_id, 1);
      chk("solo_ext", out_ext, 32'hFFFF_8000);
      chk("solo_gap", req1_ready, 0);
      @(negedge clk);
    end
    req1_valid = 1'b0;

    // Boundary operands.
    do_one("b7fff", 16'h7FFF, 2'b11, 32'h0001_FFFC);
    do_one("b8000", 16'h8000, 2'b10, 32'h8000_0000);
    do_one("z0", 16'h0000, 2'b00, 32'h0);
    do_one("z1", 16'h0000, 2'b01, 32'h0);
    do_one("z2", 16'h0000, 2'b10, 32'h0);
    do_one("z3", 16'h0000, 2'b11, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
